// File: rtl/aes_dec_sequencer_if.sv
// Streaming ciphertext-in / plaintext-out bus for aes_dec_sequencer.
// master: block producer and plaintext consumer side.
// slave : the sequencer itself.
interface aes_dec_sequencer_if;
  logic         IN_VALID;
  logic         IN_READY;
  logic [127:0] IN_DATA;
  logic         OUT_VALID;
  logic         OUT_READY;
  logic [127:0] OUT_DATA;

  modport master (
    output IN_VALID, IN_DATA, OUT_READY,
    input  IN_READY, OUT_VALID, OUT_DATA
  );

  modport slave (
    input  IN_VALID, IN_DATA, OUT_READY,
    output IN_READY, OUT_VALID, OUT_DATA
  );
endinterface

// File: rtl/aes_dec_sequencer.sv
// aes_dec_sequencer: multi-block ECB/CBC streaming front end for the
// single-block AES decryption core (START/DONE level handshake).
// Ciphertext blocks are buffered in a DEPTH-entry FIFO and the core is
// launched once per block; plaintext leaves through a one-entry output
// register on a valid/ready port.
// Optional feature macro: AES_SEQ_TIMEOUT_EN adds TIMEOUT_CYC and the sticky
// ERR output; without it WAIT waits for CORE_DONE indefinitely.
module aes_dec_sequencer #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
`ifdef AES_SEQ_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYC = 1024
`endif
) (
  input  logic               CLK,
  input  logic               RESET_N,
  input  logic [127:0]       KEY,
  input  logic               KEY_LOAD,
  input  logic [127:0]       IV,
  input  logic               IV_LOAD,
  input  logic               MODE,
  aes_dec_sequencer_if.slave stream,
  output logic               CORE_START,
  input  logic               CORE_DONE,
  output logic [127:0]       CORE_KEY,
  output logic [127:0]       CORE_MSG_ENC,
  input  logic [127:0]       CORE_MSG_DEC,
  output logic               BUSY,
  output logic [CNT_W-1:0]   BLK_COUNT
`ifdef AES_SEQ_TIMEOUT_EN
  ,
  output logic               ERR
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LAUNCH,
    ST_WAIT,
    ST_RELEASE
  } state_t;

  state_t             state_reg, state_next;
  logic [PW-1:0]      wr_ptr_reg, wr_ptr_next;
  logic [PW-1:0]      rd_ptr_reg, rd_ptr_next;
  logic [127:0]       mem [DEPTH];
  logic [127:0]       key_reg, key_next;
  logic [127:0]       chain_reg, chain_next;
  logic [127:0]       msg_reg, msg_next;
  logic [127:0]       out_data_reg, out_data_next;
  logic               out_valid_reg, out_valid_next;
  logic               start_reg, start_next;
  logic               mode_reg, mode_next;
  logic [CNT_W-1:0]   count_reg, count_next;
  logic               fifo_empty;
  logic               fifo_full;
  logic               push;
  logic [127:0]       fifo_head;

`ifdef AES_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0]      tmo_reg, tmo_next;
  logic               err_reg, err_next;
`endif

  // Wrap bit distinguishes full from empty when the index bits match.
  assign fifo_empty = (wr_ptr_reg == rd_ptr_reg);
  assign fifo_full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                      (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign fifo_head  = mem[rd_ptr_reg[AW-1:0]];

  // Ready is forced low during reset so nothing is pushed into a clearing FIFO.
  assign stream.IN_READY = RESET_N && !fifo_full;
  assign push            = stream.IN_VALID && stream.IN_READY;

  assign stream.OUT_VALID = out_valid_reg;
  assign stream.OUT_DATA  = out_data_reg;
  assign CORE_START       = start_reg;
  assign CORE_KEY         = key_reg;
  assign CORE_MSG_ENC     = msg_reg;
  assign BLK_COUNT        = count_reg;
  assign BUSY             = (state_reg != ST_IDLE) || !fifo_empty;
`ifdef AES_SEQ_TIMEOUT_EN
  assign ERR              = err_reg;
`endif

  // FIFO storage: write-only array, emptied by resetting the pointers.
  always_ff @(posedge CLK) begin
    if (push) begin
      mem[wr_ptr_reg[AW-1:0]] <= stream.IN_DATA;
    end
  end

  // State register: every piece of sequencer state, cleared asynchronously.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_reg     <= ST_IDLE;
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      key_reg       <= '0;
      chain_reg     <= '0;
      msg_reg       <= '0;
      out_data_reg  <= '0;
      out_valid_reg <= 1'b0;
      start_reg     <= 1'b0;
      mode_reg      <= 1'b0;
      count_reg     <= '0;
`ifdef AES_SEQ_TIMEOUT_EN
      tmo_reg       <= '0;
      err_reg       <= 1'b0;
`endif
    end else begin
      state_reg     <= state_next;
      wr_ptr_reg    <= wr_ptr_next;
      rd_ptr_reg    <= rd_ptr_next;
      key_reg       <= key_next;
      chain_reg     <= chain_next;
      msg_reg       <= msg_next;
      out_data_reg  <= out_data_next;
      out_valid_reg <= out_valid_next;
      start_reg     <= start_next;
      mode_reg      <= mode_next;
      count_reg     <= count_next;
`ifdef AES_SEQ_TIMEOUT_EN
      tmo_reg       <= tmo_next;
      err_reg       <= err_next;
`endif
    end
  end

  // Next-state logic: FIFO pointers, output handshake and the launch FSM.
  always_comb begin
    state_next     = state_reg;
    wr_ptr_next    = push ? wr_ptr_reg + PW'(1) : wr_ptr_reg;
    rd_ptr_next    = rd_ptr_reg;
    key_next       = key_reg;
    chain_next     = chain_reg;
    msg_next       = msg_reg;
    out_data_next  = out_data_reg;
    out_valid_next = out_valid_reg;
    start_next     = 1'b0;
    mode_next      = mode_reg;
    count_next     = count_reg;
`ifdef AES_SEQ_TIMEOUT_EN
    tmo_next       = tmo_reg;
    err_next       = err_reg;
`endif

    // Consumer takes the held plaintext block.
    if (out_valid_reg && stream.OUT_READY) begin
      out_valid_next = 1'b0;
      count_next     = count_reg + CNT_W'(1);
    end

    case (state_reg)
      ST_IDLE: begin
        // Key/IV only change when nothing is queued or in flight, so a
        // stream is never decrypted with a mix of old and new settings.
        if (fifo_empty) begin
          if (KEY_LOAD) begin
            key_next = KEY;
          end
          if (IV_LOAD) begin
            chain_next = IV;
`ifdef AES_SEQ_TIMEOUT_EN
            err_next   = 1'b0;
`endif
          end
        end
        // Launch only with a free output register and the core's DONE low.
        if (!fifo_empty && !out_valid_reg && !CORE_DONE) begin
          msg_next    = fifo_head;
          rd_ptr_next = rd_ptr_reg + PW'(1);
          mode_next   = MODE;
          state_next  = ST_LAUNCH;
        end
      end

      ST_LAUNCH: begin
        start_next = 1'b1;
        state_next = ST_WAIT;
`ifdef AES_SEQ_TIMEOUT_EN
        tmo_next   = '0;
`endif
      end

      ST_WAIT: begin
        start_next = 1'b1;
        if (CORE_DONE) begin
          start_next     = 1'b0;
          out_valid_next = 1'b1;
          state_next     = ST_RELEASE;
          if (mode_reg) begin
            out_data_next = CORE_MSG_DEC ^ chain_reg;
            chain_next    = msg_reg;
          end else begin
            out_data_next = CORE_MSG_DEC;
          end
        end
`ifdef AES_SEQ_TIMEOUT_EN
        else if (tmo_reg == TW'(TIMEOUT_CYC - 1)) begin
          // Core hung: drop the block, keep the chain, flag the error.
          start_next = 1'b0;
          err_next   = 1'b1;
          state_next = ST_RELEASE;
        end else begin
          tmo_next = tmo_reg + TW'(1);
        end
`endif
      end

      ST_RELEASE: begin
        if (!CORE_DONE) begin
          state_next = ST_IDLE;
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_aes_dec_sequencer.sv
// Directed testbench for aes_dec_sequencer with a behavioural AES core:
// the known FIPS-197 ciphertext under the known key maps to its plaintext,
// any other block decrypts to msg ^ key. Optional macro AES_SEQ_TIMEOUT_EN
// enables the timeout scenario.
module tb_aes_dec_sequencer;

  localparam logic [127:0] K0   = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C0   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] P0   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] P0X  = 128'hffeeddccbbaa99887766554433221100;
  localparam logic [127:0] P1   = 128'h69d5c2eb2e2e624750541d3bbc692ba5;
  localparam logic [127:0] ONES = {128{1'b1}};
  localparam int CORE_LAT = 5;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [127:0] key;
  logic         key_load;
  logic [127:0] iv;
  logic         iv_load;
  logic         mode;
  logic         core_start;
  logic         core_done;
  logic         core_hang;
  logic [127:0] core_key;
  logic [127:0] core_enc;
  logic [127:0] core_dec;
  logic         busy;
  logic [15:0]  blk_count;
  int           core_cnt;
`ifdef AES_SEQ_TIMEOUT_EN
  logic         err;
`endif

  int checks = 0;
  int errors = 0;
  logic [127:0] exp_q[$];

  aes_dec_sequencer_if bus ();

  always #5 clk = ~clk;

  aes_dec_sequencer #(
    .DEPTH(4),
    .CNT_W(16)
`ifdef AES_SEQ_TIMEOUT_EN
    ,
    .TIMEOUT_CYC(16)
`endif
  ) dut (
    .CLK(clk),
    .RESET_N(rst_n),
    .KEY(key),
    .KEY_LOAD(key_load),
    .IV(iv),
    .IV_LOAD(iv_load),
    .MODE(mode),
    .stream(bus.slave),
    .CORE_START(core_start),
    .CORE_DONE(core_done),
    .CORE_KEY(core_key),
    .CORE_MSG_ENC(core_enc),
    .CORE_MSG_DEC(core_dec),
    .BUSY(busy),
    .BLK_COUNT(blk_count)
`ifdef AES_SEQ_TIMEOUT_EN
    ,
    .ERR(err)
`endif
  );

  // Behavioural core: DONE rises CORE_LAT cycles after START, drops after START drops.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      core_done <= 1'b0;
      core_cnt  <= 0;
      core_dec  <= '0;
    end else if (core_start && !core_done) begin
      if (!core_hang) begin
        if (core_cnt == CORE_LAT - 1) begin
          core_done <= 1'b1;
          core_cnt  <= 0;
          core_dec  <= (core_enc == C0 && core_key == K0) ? P0 : (core_enc ^ core_key);
        end else begin
          core_cnt <= core_cnt + 1;
        end
      end
    end else if (!core_start) begin
      core_done <= 1'b0;
      core_cnt  <= 0;
    end
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Scoreboard: every accepted plaintext block is compared in order.
  always @(negedge clk) begin
    if (rst_n && bus.OUT_VALID && bus.OUT_READY) begin
      if (exp_q.size() == 0) begin
        check("out_extra", 128'(exp_q.size()), 128'd1);
      end else begin
        check("out_data", bus.OUT_DATA, exp_q.pop_front());
      end
    end
  end

  task automatic push(input logic [127:0] d);
    int n;
    n = 0;
    bus.IN_VALID = 1'b1;
    bus.IN_DATA  = d;
    @(negedge clk);
    while (!bus.IN_READY && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("push_accept", 128'(bus.IN_READY), 128'd1);
    @(posedge clk);
    #1;
    bus.IN_VALID = 1'b0;
    $display("push %h", d);
  endtask

  task automatic load(input logic kl, input logic [127:0] kv, input logic il, input logic [127:0] ivv);
    key      = kv;
    key_load = kl;
    iv       = ivv;
    iv_load  = il;
    @(posedge clk);
    #1;
    key_load = 1'b0;
    iv_load  = 1'b0;
  endtask

  task automatic wait_start();
    int n;
    n = 0;
    while (!core_start && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("start_seen", 128'(core_start), 128'd1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 1000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_left", 128'(exp_q.size()), 128'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n        = 1'b0;
    key          = '0;
    key_load     = 1'b0;
    iv           = '0;
    iv_load      = 1'b0;
    mode         = 1'b0;
    core_hang    = 1'b0;
    bus.IN_VALID = 1'b0;
    bus.IN_DATA  = '0;
    bus.OUT_READY = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_start", 128'(core_start), 128'd0);
    check("rst_out_valid", 128'(bus.OUT_VALID), 128'd0);
    check("rst_busy", 128'(busy), 128'd0);
    check("rst_count", 128'(blk_count), 128'd0);
    check("rst_in_ready", 128'(bus.IN_READY), 128'd0);
    check("rst_out_data", bus.OUT_DATA, 128'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rel_in_ready", 128'(bus.IN_READY), 128'd1);

    // ECB single block with launch latency
    load(1'b1, K0, 1'b0, '0);
    check("key_load", core_key, K0);
    mode = 1'b0;
    bus.OUT_READY = 1'b1;
    exp_q.push_back(P0);
    push(C0);
    check("lat_push", 128'(core_start), 128'd0);
    @(posedge clk);
    #1;
    check("lat_pop", 128'(core_start), 128'd0);
    @(posedge clk);
    #1;
    check("lat_launch", 128'(core_start), 128'd1);
    drain();
    check("ecb_count", 128'(blk_count), 128'd1);

    // CBC two blocks; key/IV loads while busy must be ignored
    load(1'b0, '0, 1'b1, ONES);
    mode = 1'b1;
    exp_q.push_back(P0X);
    exp_q.push_back(P1);
    push(C0);
    check("cbc_busy", 128'(busy), 128'd1);
    load(1'b1, ONES, 1'b1, '0);
    check("ignored_key", core_key, K0);
    push(C0);
    drain();
    check("cbc_count", 128'(blk_count), 128'd3);

    // Backpressure: consumer stalled, FIFO fills, then drains in order
    mode = 1'b0;
    bus.OUT_READY = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      exp_q.push_back({4{32'hC0DE_0000 + 32'(i)}} ^ K0);
    end
    for (int i = 1; i <= 5; i++) begin
      push({4{32'hC0DE_0000 + 32'(i)}});
    end
    repeat (25) @(posedge clk);
    #1;
    check("bp_in_ready", 128'(bus.IN_READY), 128'd0);
    check("bp_out_valid", 128'(bus.OUT_VALID), 128'd1);
    check("bp_out_data", bus.OUT_DATA, {4{32'hC0DE_0001}} ^ K0);
    repeat (10) @(posedge clk);
    #1;
    check("bp_stable", bus.OUT_DATA, {4{32'hC0DE_0001}} ^ K0);
    check("bp_start_idle", 128'(core_start), 128'd0);
    bus.OUT_READY = 1'b1;
    push({4{32'hC0DE_0006}});
    drain();
    check("bp_count", 128'(blk_count), 128'd9);

    // Reset during WAIT
    push(C0);
    push(C0);
    wait_start();
    rst_n = 1'b0;
    #2;
    check("mid_rst_start", 128'(core_start), 128'd0);
    check("mid_rst_valid", 128'(bus.OUT_VALID), 128'd0);
    check("mid_rst_busy", 128'(busy), 128'd0);
    check("mid_rst_count", 128'(blk_count), 128'd0);
    check("mid_rst_key", core_key, 128'd0);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("mid_rel_ready", 128'(bus.IN_READY), 128'd1);
    repeat (20) @(posedge clk);
    #1;
    check("mid_no_launch", 128'(core_start), 128'd0);
    check("mid_no_out", 128'(bus.OUT_VALID), 128'd0);

    // Simultaneous key + IV load, then a CBC block on the fresh chain
    load(1'b1, K0, 1'b1, ONES);
    check("dual_key", core_key, K0);
    mode = 1'b1;
    exp_q.push_back(P0X);
    push(C0);
    drain();
    check("post_rst_count", 128'(blk_count), 128'd1);

`ifdef AES_SEQ_TIMEOUT_EN
    // Hung core: timeout after 16 WAIT cycles, no output, sticky ERR
    core_hang = 1'b1;
    mode = 1'b0;
    push(C0);
    wait_start();
    repeat (15) @(posedge clk);
    #1;
    check("tmo_err_early", 128'(err), 128'd0);
    check("tmo_start_held", 128'(core_start), 128'd1);
    @(posedge clk);
    #1;
    check("tmo_err", 128'(err), 128'd1);
    check("tmo_no_out", 128'(bus.OUT_VALID), 128'd0);
    repeat (5) @(posedge clk);
    #1;
    check("tmo_err_sticky", 128'(err), 128'd1);
    check("tmo_count", 128'(blk_count), 128'd1);
    load(1'b0, '0, 1'b1, '0);
    check("tmo_err_clear", 128'(err), 128'd0);
    core_hang = 1'b0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/aes_dec_sequencer.md
Name: aes_dec_sequencer

Overview:
- Multi-block streaming front end for the existing single-block AES decryption core (START/DONE level handshake).
- Buffers ciphertext blocks in a parametrised FIFO and launches the core once per block.
- Supports ECB and CBC decryption; returns plaintext on a valid/ready output port.
- Sits between the Avalon/software-facing register block and the AES core instance.

Parameters:
- DEPTH, 4, input FIFO depth in 128-bit blocks; power of two, >= 2.
- CNT_W, 16, width of the completed-block counter.

Ports:
- CLK  in  1  system clock; all state is on the rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- KEY  in  128  cipher key; captured into the key register on KEY_LOAD.
- KEY_LOAD  in  1  one-cycle pulse; honoured only when idle.
- IV  in  128  CBC initial vector; captured into the chain register on IV_LOAD.
- IV_LOAD  in  1  one-cycle pulse; honoured only when idle.
- MODE  in  1  0 = ECB, 1 = CBC; sampled per block at launch.
- IN_VALID  in  1  ciphertext block offered.
- IN_READY  out  1  equals FIFO not full.
- IN_DATA  in  128  ciphertext block.
- OUT_VALID  out  1  plaintext block held in the output register.
- OUT_READY  in  1  consumer accepts the block.
- OUT_DATA  out  128  plaintext block.
- CORE_START  out  1  drives the core's AES_START.
- CORE_DONE  in  1  from the core's AES_DONE.
- CORE_KEY  out  128  key register, drives the core's AES_KEY.
- CORE_MSG_ENC  out  128  ciphertext being decrypted.
- CORE_MSG_DEC  in  128  core result.
- BUSY  out  1  high when not IDLE or when the FIFO is non-empty.
- BLK_COUNT  out  CNT_W  count of blocks accepted on the output; wraps.

Behaviour:
- Reset (asynchronous, active low). All of the following clear immediately, including mid-operation; any in-flight block is discarded:
  - outputs CORE_START, OUT_VALID, BUSY and BLK_COUNT go to 0; OUT_DATA, CORE_MSG_ENC and CORE_KEY go to 0.
  - FIFO is emptied; the chain register is cleared to 0; FSM returns to IDLE.
  - IN_READY is 0 while reset is asserted and 1 from the first cycle after release.
- FIFO:
  - A push occurs when IN_VALID && IN_READY.
  - When full, IN_READY=0 and no push occurs, even if the same cycle pops.
  - Pointers are log2(DEPTH) bits wide plus a wrap bit; a push and a pop in the same cycle while not full keep the occupancy count unchanged.
- FSM state IDLE:
  - KEY_LOAD and IV_LOAD are honoured only here.
  - When the FIFO is non-empty and OUT_VALID=0 and CORE_DONE=0: pop the FIFO head into CORE_MSG_ENC, latch MODE into mode_r, go to LAUNCH.
- FSM state LAUNCH: CORE_START=1 (registered); go to WAIT.
- FSM state WAIT:
  - CORE_START is held at 1.
  - On CORE_DONE=1, compute the result and go to RELEASE:
    - ECB: OUT_DATA <= CORE_MSG_DEC.
    - CBC: OUT_DATA <= CORE_MSG_DEC ^ chain; chain <= CORE_MSG_ENC.
  - OUT_VALID <= 1 in the same edge.
- FSM state RELEASE:
  - CORE_START=0.
  - Wait until CORE_DONE=0, then go to IDLE.
  - The next launch is never earlier than the cycle after CORE_DONE is observed low.
- Output handshake:
  - OUT_VALID stays high, and OUT_DATA stays stable, until OUT_VALID && OUT_READY.
  - On that handshake cycle, OUT_VALID clears and BLK_COUNT increments, wrapping from all ones to 0.
  - Only one block may be in flight plus one held in the output register; no launch occurs while OUT_VALID=1.
- Ignored / simultaneous events:
  - KEY_LOAD or IV_LOAD while BUSY: ignored, no state change.
  - IV_LOAD and KEY_LOAD in the same idle cycle: both are captured.
  - MODE changes mid-stream take effect at the next launch only.
- Latency: first IN_DATA push to CORE_START high is 3 cycles (push, pop/IDLE, LAUNCH), plus the core latency.

Optional Feature:
- Macro: AES_SEQ_TIMEOUT_EN.
- Defined:
  - Adds parameter TIMEOUT_CYC (default 1024) and output port ERR (1 bit).
  - A counter runs in WAIT. If it reaches TIMEOUT_CYC without CORE_DONE, the FSM goes to RELEASE with no output and sets ERR=1 (sticky).
  - The chain register is unchanged and BLK_COUNT does not increment.
  - ERR is cleared only by reset or by IV_LOAD while idle.
- Not defined: there is no ERR port or counter, and WAIT waits indefinitely.

Test Plan:
- ECB single block (sequencer driving the real AES core):
  - Stimulus: KEY=000102030405060708090a0b0c0d0e0f, MODE=0, IN_DATA=69c4e0d86a7b0430d8cdb78070b4c55a.
  - Required: OUT_DATA=00112233445566778899aabbccddeeff; BLK_COUNT=1.
- CBC two blocks:
  - Stimulus: same key, IV=all ff, MODE=1, push the ciphertext above twice.
  - Required: first output ffeeddccbbaa99887766554433221100, second 69d5c2eb2e2e624750541d3bbc692ba5.
- Backpressure:
  - Stimulus: DEPTH=4, OUT_READY=0, push 6 blocks.
  - Required: IN_READY=0 after 4 outstanding FIFO entries; OUT_DATA stable; the remaining blocks drain in order once OUT_READY=1; BLK_COUNT=6.
- Reset mid-operation:
  - Stimulus: assert RESET_N=0 during WAIT.
  - Required: CORE_START=0 and OUT_VALID=0 without a clock edge; FIFO empty; a subsequent ECB block decrypts correctly.
- Ignored loads:
  - Stimulus: IV_LOAD with IV=0 while BUSY in CBC.
  - Required: chaining is unaffected; output matches the two-block CBC vector.
- Timeout (AES_SEQ_TIMEOUT_EN, behavioural core that never asserts DONE, TIMEOUT_CYC=16):
  - Required: ERR=1 after 16 WAIT cycles; OUT_VALID stays 0.
